// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_ctrl_if: handshaked memory port between the miss handler (master) and memory (slave)
interface cache_fill_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss handler that writes back a dirty victim block, then refills the missing block
module cache_fill_ctrl #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS           = 8,
    parameter int BYTES_PER_WORD  = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       miss_detected,
    input  logic [ADDR_W-1:0]          miss_address,
    input  logic                       victim_dirty,
    input  logic [ADDR_W-1:0]          victim_address,
    input  logic [DATA_W-1:0]          victim_data,
    output logic [$clog2(WORDS)-1:0]   wb_word_idx,
    cache_fill_ctrl_if.master          mem,
    output logic                       fsm_busy,
    output logic                       write_data_array,
    output logic [WORDS-1:0]           word_en,
    output logic [DATA_W-1:0]          fill_data,
    output logic                       write_tag_array,
    output logic [1:0]                 state
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF   = $clog2(WORDS * BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF) - 1);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0]  LAST      = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  MAX_OUT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [WORDS-1:0]  ONE       = WORDS'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2, DONE = 2'd3} state_t;

    state_t            cur, nxt;
    logic [ADDR_W-1:0] miss_base, victim_base;
    logic [CNT_W-1:0]  wb_cnt, issue_cnt, rsp_cnt, outstanding;
    logic              wb_acc, rd_acc, rsp;

    assign wb_acc = (cur == WB) & mem.mem_req_valid & mem.mem_req_ready;
    assign rd_acc = (cur == FILL) & mem.mem_req_valid & mem.mem_req_ready;
    assign rsp    = (cur == FILL) & mem.mem_rsp_valid;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cur <= IDLE;
        else
            cur <= nxt;
    end

    // Counters are cleared while idle so a miss can start on the cycle after DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_base   <= '0;
            victim_base <= '0;
            wb_cnt      <= '0;
            issue_cnt   <= '0;
            rsp_cnt     <= '0;
            outstanding <= '0;
        end else if (cur == IDLE) begin
            wb_cnt      <= '0;
            issue_cnt   <= '0;
            rsp_cnt     <= '0;
            outstanding <= '0;
            if (miss_detected) begin
                miss_base   <= miss_address & BASE_MASK;
                victim_base <= victim_address & BASE_MASK;
            end
        end else begin
            wb_cnt      <= wb_cnt + CNT_W'(wb_acc);
            issue_cnt   <= issue_cnt + CNT_W'(rd_acc);
            rsp_cnt     <= rsp_cnt + CNT_W'(rsp);
            outstanding <= outstanding + CNT_W'(rd_acc) - CNT_W'(rsp);
        end
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:    nxt = miss_detected ? (victim_dirty ? WB : FILL) : IDLE;
            WB:      nxt = (wb_acc && wb_cnt == LAST) ? FILL : WB;
            FILL:    nxt = (rsp && rsp_cnt == LAST) ? DONE : FILL;
            default: nxt = IDLE;
        endcase
    end

    // A stalled read keeps its address because issue_cnt only moves on accept and
    // outstanding can only shrink meanwhile, so valid cannot drop before the accept.
    always_comb begin
        mem.mem_req_valid = 1'b0;
        mem.mem_req_we    = 1'b0;
        mem.mem_req_addr  = '0;
        mem.mem_req_wdata = victim_data;
        write_data_array  = rsp;
        word_en           = rsp ? ONE << rsp_cnt[IDX_W-1:0] : '0;
        fill_data         = mem.mem_rsp_data;
        write_tag_array   = cur == DONE;
        fsm_busy          = (cur != IDLE) | miss_detected;
        state             = cur;
        wb_word_idx       = wb_cnt[IDX_W-1:0];
        if (cur == WB) begin
            mem.mem_req_valid = 1'b1;
            mem.mem_req_we    = 1'b1;
            mem.mem_req_addr  = victim_base + STRIDE * ADDR_W'(wb_cnt[IDX_W-1:0]);
        end else if (cur == FILL) begin
            mem.mem_req_valid = (issue_cnt < FULL) && (outstanding < MAX_OUT);
            mem.mem_req_addr  = miss_base + STRIDE * ADDR_W'(issue_cnt[IDX_W-1:0]);
        end
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: randomized scoreboard bench; a block-level miss model predicts every
// memory request and array write, an in-order memory model answers reads.
`timescale 1ns/1ps
module tb_cache_fill_ctrl;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int WORDS  = 8;
    localparam int BPW    = 2;
    localparam int MAXO   = 4;
    localparam int BLK    = WORDS * BPW;

    typedef struct { logic we; logic [15:0] addr; logic [15:0] data; } req_t;
    typedef struct { logic [WORDS-1:0] en; logic [15:0] data; } fill_t;
    typedef struct { logic [15:0] addr; int due; } pend_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              miss_detected = 1'b0;
    logic              victim_dirty = 1'b0;
    logic [15:0]       miss_address = '0;
    logic [15:0]       victim_address = '0;
    logic [15:0]       vseed = '0;
    logic [15:0]       victim_data;
    logic [2:0]        wb_word_idx;
    logic              fsm_busy, write_data_array, write_tag_array;
    logic [WORDS-1:0]  word_en;
    logic [15:0]       fill_data;
    logic [1:0]        state;

    cache_fill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();

    cache_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS),
                      .BYTES_PER_WORD(BPW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
        .victim_dirty(victim_dirty), .victim_address(victim_address), .victim_data(victim_data),
        .wb_word_idx(wb_word_idx), .mem(mem), .fsm_busy(fsm_busy),
        .write_data_array(write_data_array), .word_en(word_en), .fill_data(fill_data),
        .write_tag_array(write_tag_array), .state(state)
    );

    always #5 clk = ~clk;

    // Victim block contents as seen through the data-array read port.
    assign victim_data = vseed + 16'(wb_word_idx) * 16'h1111;

    int    tests = 0, fails = 0, cyc = 0;
    int    ready_pct = 100, lat_min = 1, lat_max = 1;
    logic  spur = 1'b0;
    req_t  req_q[$];
    fill_t fill_q[$];
    pend_t pend[$];
    int    miss_cyc, fill_at, done_at, tag_cnt, wr_cnt, acc_cnt, acc_before, max_out;
    logic  seen_rsp;

    function automatic logic [15:0] mem_word(logic [15:0] a);
        return (a * 16'h9E37) ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] block_of(logic [15:0] a);
        return 16'((int'(a) / BLK) * BLK);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
        #1;
    endtask

    task automatic expect_miss(logic [15:0] addr, logic dirty, logic [15:0] vaddr, logic [15:0] seed);
        logic [15:0] mb, vb;
        mb = block_of(addr);
        vb = block_of(vaddr);
        if (dirty)
            for (int i = 0; i < WORDS; i++)
                req_q.push_back('{1'b1, 16'(vb + i * BPW), 16'(seed + 16'(i) * 16'h1111)});
        for (int i = 0; i < WORDS; i++) begin
            req_q.push_back('{1'b0, 16'(mb + i * BPW), 16'h0});
            fill_q.push_back('{WORDS'(1) << i, mem_word(16'(mb + i * BPW))});
        end
    endtask

    task automatic clear_stats;
        fill_at = -1; done_at = -1; tag_cnt = 0; wr_cnt = 0;
        acc_cnt = 0; acc_before = 0; max_out = 0; seen_rsp = 1'b0;
    endtask

    task automatic start_miss(logic [15:0] addr, logic dirty, logic [15:0] vaddr);
        tick;
        vseed = 16'($urandom);
        expect_miss(addr, dirty, vaddr, vseed);
        clear_stats();
        miss_address = addr;
        victim_address = vaddr;
        victim_dirty = dirty;
        miss_detected = 1'b1;
        miss_cyc = cyc;
        tick;
        miss_detected = 1'b0;
    endtask

    task automatic wait_done(string name, int tags);
        int n;
        n = 0;
        while (!(tag_cnt >= tags && state == 2'd0) && n < 2000) begin
            smp;
            n++;
        end
        check({name, "_completes"}, n < 2000, 1);
        check({name, "_tag_pulses"}, tag_cnt, tags);
        check({name, "_array_writes"}, wr_cnt, tags * WORDS);
        check({name, "_req_left"}, req_q.size(), 0);
        check({name, "_fill_left"}, fill_q.size(), 0);
    endtask

    // Memory model: random ready, in-order responses after a per-request latency.
    initial begin
        mem.mem_req_ready = 1'b0;
        mem.mem_rsp_valid = 1'b0;
        mem.mem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                pend.delete();
                mem.mem_req_ready = 1'b0;
                mem.mem_rsp_valid = 1'b0;
            end else begin
                mem.mem_req_ready = ready_pct < 0 ? cyc[0] : (int'($urandom_range(99)) < ready_pct);
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    mem.mem_rsp_valid = 1'b1;
                    mem.mem_rsp_data  = mem_word(pend[0].addr);
                    void'(pend.pop_front());
                end else begin
                    mem.mem_rsp_valid = spur;
                    mem.mem_rsp_data  = 16'($urandom);
                end
            end
        end
    end

    // Monitor: compares every accepted request and array write against the scoreboard queues.
    initial begin
        logic        stall, s_we;
        logic [15:0] s_addr, s_wdata;
        logic [1:0]  prev_state;
        req_t        e;
        fill_t       f;
        stall = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; prev_state = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                prev_state = 2'd0;
                pend.delete();
                continue;
            end
            if (prev_state == 2'd3)
                check("done_then_idle", state, 2'd0);
            prev_state = state;
            if (state == 2'd2 && fill_at < 0) fill_at = cyc - miss_cyc;
            if (state == 2'd3 && done_at < 0) done_at = cyc - miss_cyc;
            if (stall) begin
                check("hold_valid", mem.mem_req_valid, 1);
                check("hold_addr", mem.mem_req_addr, s_addr);
                check("hold_we", mem.mem_req_we, s_we);
                if (s_we) check("hold_wdata", mem.mem_req_wdata, s_wdata);
            end
            if (mem.mem_req_valid && mem.mem_req_ready) begin
                acc_cnt++;
                if (req_q.size() == 0) begin
                    check("unexpected_request", mem.mem_req_addr, 16'hFFFF);
                end else begin
                    e = req_q.pop_front();
                    check("req_we", mem.mem_req_we, e.we);
                    check("req_addr", mem.mem_req_addr, e.addr);
                    if (e.we) check("req_wdata", mem.mem_req_wdata, e.data);
                end
                if (!mem.mem_req_we) begin
                    if (!seen_rsp) acc_before++;
                    pend.push_back('{mem.mem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
                    if (pend.size() > max_out) max_out = pend.size();
                    check("outstanding_bound", pend.size() <= MAXO, 1);
                end
            end
            if (write_data_array) begin
                seen_rsp = 1'b1;
                wr_cnt++;
                if (fill_q.size() == 0) begin
                    check("unexpected_array_write", word_en, '0);
                end else begin
                    f = fill_q.pop_front();
                    check("word_en", word_en, f.en);
                    check("fill_data", fill_data, f.data);
                end
            end else if (word_en != '0) begin
                check("word_en_without_write", word_en, '0);
            end
            if (write_tag_array) tag_cnt++;
            stall = mem.mem_req_valid && !mem.mem_req_ready;
            s_addr = mem.mem_req_addr;
            s_we = mem.mem_req_we;
            s_wdata = mem.mem_req_wdata;
        end
    end

    initial begin
        int n;
        clear_stats();
        miss_cyc = 0;
        repeat (3) tick;
        smp;
        check("reset_state", state, 2'd0);
        check("reset_valid", mem.mem_req_valid, 0);
        check("reset_word_en", word_en, '0);
        check("reset_wda", write_data_array, 0);
        check("reset_tag", write_tag_array, 0);
        check("reset_busy", fsm_busy, 0);
        tick;
        rst_n = 1'b1;

        // Clean miss, responses two cycles after accept.
        ready_pct = 100; lat_min = 2; lat_max = 2;
        start_miss(16'h1234, 1'b0, 16'h0000);
        wait_done("clean", 1);

        // Latency with ready=1 and one-cycle responses; accept+response overlap keeps outstanding at 1.
        lat_min = 1; lat_max = 1;
        start_miss(16'h2006, 1'b0, 16'h0000);
        wait_done("lat_clean", 1);
        check("lat_clean_fill_at", fill_at, 1);
        check("lat_clean_done_at", done_at, WORDS + 2);
        check("lat_clean_max_out", max_out, 1);
        start_miss(16'h3456, 1'b1, 16'h789A);
        wait_done("lat_dirty", 1);
        check("lat_dirty_fill_at", fill_at, WORDS + 1);
        check("lat_dirty_done_at", done_at, 2 * WORDS + 2);

        // Dirty miss with writeback.
        lat_min = 2; lat_max = 2;
        start_miss(16'h1234, 1'b1, 16'hA0F7);
        wait_done("dirty", 1);

        // Toggling ready.
        ready_pct = -1;
        start_miss(16'h1234, 1'b0, 16'h0000);
        wait_done("toggle_clean", 1);
        check("toggle_clean_accepts", acc_cnt, WORDS);
        start_miss(16'h4321, 1'b1, 16'h55AA);
        wait_done("toggle_dirty", 1);
        check("toggle_dirty_accepts", acc_cnt, 2 * WORDS);

        // Long response latency saturates the outstanding limit.
        ready_pct = 100; lat_min = 10; lat_max = 10;
        start_miss(16'h0ABC, 1'b0, 16'h0000);
        wait_done("slow", 1);
        check("slow_accepts_before_rsp", acc_before, MAXO);
        check("slow_max_out", max_out, MAXO);

        // Reset in FILL after three responses, then spurious responses while idle.
        lat_min = 2; lat_max = 2;
        start_miss(16'h0300, 1'b0, 16'h0000);
        n = 0;
        while (wr_cnt < 3 && n < 200) begin
            smp;
            n++;
        end
        check("rst_reached_three", wr_cnt, 3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        req_q.delete();
        fill_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        smp;
        check("rst_state_idle", state, 2'd0);
        check("rst_valid_low", mem.mem_req_valid, 0);
        check("rst_no_tag", write_tag_array, 0);
        check("rst_no_wda", write_data_array, 0);
        tick;
        spur = 1'b1;
        repeat (5) tick;
        spur = 1'b0;
        repeat (3) tick;
        check("rst_tag_count", tag_cnt, 0);
        check("rst_no_late_writes", wr_cnt, 3);
        start_miss(16'h0040, 1'b0, 16'h0000);
        wait_done("after_rst", 1);

        // Miss held through DONE: one IDLE cycle, then the next miss starts.
        lat_min = 1; lat_max = 1;
        tick;
        vseed = 16'($urandom);
        expect_miss(16'h0500, 1'b0, 16'h0000, vseed);
        expect_miss(16'h0500, 1'b0, 16'h0000, vseed);
        clear_stats();
        miss_address = 16'h0500;
        victim_dirty = 1'b0;
        miss_detected = 1'b1;
        miss_cyc = cyc;
        n = 0;
        while (tag_cnt < 1 && n < 200) begin
            smp;
            n++;
        end
        check("held_first_done", state, 2'd3);
        smp;
        check("held_idle_gap", state, 2'd0);
        check("held_idle_busy", fsm_busy, 1);
        smp;
        check("held_restart", state, 2'd2);
        n = 0;
        while (tag_cnt < 2 && n < 200) begin
            smp;
            n++;
        end
        tick;
        miss_detected = 1'b0;
        wait_done("held", 2);
        check("held_max_out", max_out, 1);

        // Randomized misses.
        for (int k = 0; k < 12; k++) begin
            ready_pct = (k == 5) ? -1 : int'($urandom_range(100, 40));
            lat_min = int'($urandom_range(3, 1));
            lat_max = lat_min + int'($urandom_range(4, 0));
            start_miss(16'($urandom), 1'($urandom), 16'($urandom));
            wait_done("rand", 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
